stream_demux: RTL and testbench

- 1-to-LENGTH valid/ready stream distributor: the fan-out counterpart to the fan-in priority mux tree.
- Routes each input beat to the output selected by its `in_dest` field.
- Each output has a 2-entry buffer, so `in_ready` never depends combinationally on any `out_ready`.
- Sits between a single producer (e.g. a command decoder) and LENGTH independent consumers; per-destination ordering is preserved.

---
 rtl/stream_pkg.sv | 14 +
 rtl/stream_demux_slot.sv | 63 ++++++
 rtl/stream_demux.sv | 76 +++++++
 tb/tb_stream_demux.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared types and constants for the stream_demux block.
// Slot depth, drop counter width and the destination width rule.
package stream_pkg;

    localparam int SLOT_DEPTH       = 2;
    localparam int DROP_COUNT_WIDTH = 16;

    typedef logic [1:0] slot_count_t;

    function automatic int dest_width(input int len);
        return (len <= 1) ? 1 : $clog2(len);
    endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// Two-entry per-channel FIFO used by stream_demux.
// Entry 0 is always the head; full/valid derive from the count.
module stream_demux_slot
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  valid,
    output logic                  full
);

    slot_count_t           count;
    slot_count_t           count_next;
    logic [DATA_WIDTH-1:0] entry [SLOT_DEPTH];
    logic                  push_ok;
    logic                  pop_ok;

    assign valid     = (count != 2'd0);
    assign full      = (count == slot_count_t'(SLOT_DEPTH));
    assign head_data = entry[0];
    assign push_ok   = push && !full;
    assign pop_ok    = pop && valid;

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + 2'd1;
        end else if (pop_ok && !push_ok) begin
            count_next = count - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= 2'd0;
        end else begin
            count <= count_next;
        end
    end

    // Payload needs no reset; it is only observed while valid.
    always_ff @(posedge clk) begin
        unique case (count)
            2'd0: if (push_ok) entry[0] <= push_data;
            2'd1: begin
                if (push_ok && pop_ok) begin
                    entry[0] <= push_data;
                end else if (push_ok) begin
                    entry[1] <= push_data;
                end
            end
            2'd2: if (pop_ok) entry[0] <= entry[1];
            default: ;
        endcase
    end

endmodule

// File: rtl/stream_demux.sv
// 1-to-LENGTH valid/ready stream distributor with 2-entry output slots.
// Optional STREAM_DEMUX_DROP_COUNT_EN adds a saturating drop counter.
module stream_demux
    import stream_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int LENGTH     = 4,
    localparam int DEST_WIDTH = dest_width(LENGTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DEST_WIDTH-1:0] in_dest,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data  [LENGTH],
    output logic                  out_valid [LENGTH],
    input  logic                  out_ready [LENGTH]
`ifdef STREAM_DEMUX_DROP_COUNT_EN
    ,
    output logic [DROP_COUNT_WIDTH-1:0] drop_count
`endif
);

    logic full [LENGTH];
    logic hit  [LENGTH];
    logic in_range;
    logic sel_full;
    logic accept;

    // Ready comes only from registered slot state, never from out_ready.
    always_comb begin
        in_range = 1'b0;
        sel_full = 1'b0;
        for (int i = 0; i < LENGTH; i++) begin
            hit[i] = (LENGTH == 1) || (in_dest == DEST_WIDTH'(i));
            if (hit[i]) begin
                in_range = 1'b1;
                sel_full = full[i];
            end
        end
    end

    assign in_ready = reset && !sel_full;
    assign accept   = in_valid && in_ready;

    for (genvar g = 0; g < LENGTH; g++) begin : g_slot
        stream_demux_slot #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .push     (accept && hit[g]),
            .push_data(in_data),
            .pop      (out_ready[g]),
            .head_data(out_data[g]),
            .valid    (out_valid[g]),
            .full     (full[g])
        );
    end

`ifdef STREAM_DEMUX_DROP_COUNT_EN
    logic [DROP_COUNT_WIDTH-1:0] drops;

    always_ff @(posedge clk) begin
        if (!reset) begin
            drops <= '0;
        end else if (accept && !in_range && drops != '1) begin
            drops <= drops + 1'b1;
        end
    end

    assign drop_count = drops;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Directed and randomised bench for stream_demux (LENGTH=4 and LENGTH=3).
// Drop counter checks are active when STREAM_DEMUX_DROP_COUNT_EN is set.
module tb_stream_demux;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic [1:0]  in_dest;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data  [4];
    logic        out_valid [4];
    logic        out_ready [4];

    logic [31:0] in_data3;
    logic [1:0]  in_dest3;
    logic        in_valid3;
    logic        in_ready3;
    logic [31:0] out_data3  [3];
    logic        out_valid3 [3];
    logic        out_ready3 [3];
`ifdef STREAM_DEMUX_DROP_COUNT_EN
    logic [15:0] drop_count;
    logic [15:0] drop_count3;
`endif

    int total = 0;
    int bad   = 0;

    typedef logic [31:0] dq_t[$];
    dq_t q [4];

    always #5 clk = ~clk;

    stream_demux #(.DATA_WIDTH(32), .LENGTH(4)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_dest(in_dest),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef STREAM_DEMUX_DROP_COUNT_EN
        , .drop_count(drop_count)
`endif
    );

    stream_demux #(.DATA_WIDTH(32), .LENGTH(3)) dut3 (
        .clk(clk), .reset(reset),
        .in_data(in_data3), .in_dest(in_dest3),
        .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_valid(out_valid3),
        .out_ready(out_ready3)
`ifdef STREAM_DEMUX_DROP_COUNT_EN
        , .drop_count(drop_count3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_all();
        in_valid = 1'b0;
        in_data  = '0;
        in_dest  = '0;
        for (int i = 0; i < 4; i++) out_ready[i] = 1'b0;
    endtask

    logic        exp_rdy;
    logic        do_push;
    logic [1:0]  p_dest;
    logic [31:0] p_data;
    logic        do_pop [4];

    initial begin
        reset     = 1'b0;
        idle_all();
        in_data3  = '0;
        in_dest3  = '0;
        in_valid3 = 1'b0;
        for (int i = 0; i < 3; i++) out_ready3[i] = 1'b0;

        // Reset and idle
        tick();
        in_valid = 1'b1;
        settle();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        settle();
        for (int i = 0; i < 4; i++) begin
            in_dest = 2'(i);
            settle();
            chk($sformatf("idle_ready_d%0d", i), {31'd0, in_ready}, 32'd1);
            chk($sformatf("idle_valid_%0d", i), {31'd0, out_valid[i]}, 32'd0);
        end

        // Three beats to channel 2 while it is stalled
        in_dest  = 2'd2;
        in_valid = 1'b1;
        in_data  = 32'hA1;
        settle();
        chk("a1_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_data = 32'hA2;
        settle();
        chk("a2_ready", {31'd0, in_ready}, 32'd1);
        chk("a1_latency_valid", {31'd0, out_valid[2]}, 32'd1);
        chk("a1_head", out_data[2], 32'hA1);
        tick();
        in_data = 32'hA3;
        settle();
        chk("a3_blocked", {31'd0, in_ready}, 32'd0);
        tick();
        chk("a3_held", {31'd0, in_ready}, 32'd0);
        chk("a_hold_data", out_data[2], 32'hA1);
        out_ready[2] = 1'b1;
        settle();
        chk("a_full_pop_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("a2_head", out_data[2], 32'hA2);
        chk("a3_ready_now", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        settle();
        chk("a3_head", out_data[2], 32'hA3);
        chk("a3_valid", {31'd0, out_valid[2]}, 32'd1);
        tick();
        chk("a_empty", {31'd0, out_valid[2]}, 32'd0);
        idle_all();

        // Channel 1 full with out_ready high
        in_dest  = 2'd1;
        in_valid = 1'b1;
        in_data  = 32'hB1;
        tick();
        in_data = 32'hB2;
        tick();
        in_data      = 32'hB3;
        out_ready[1] = 1'b1;
        settle();
        chk("b_full_ready", {31'd0, in_ready}, 32'd0);
        chk("b1_head", out_data[1], 32'hB1);
        tick();
        chk("b_next_ready", {31'd0, in_ready}, 32'd1);
        chk("b2_head", out_data[1], 32'hB2);
        tick();
        in_valid = 1'b0;
        settle();
        chk("b3_head", out_data[1], 32'hB3);
        tick();
        chk("b_empty", {31'd0, out_valid[1]}, 32'd0);
        chk("b_other_empty", {31'd0, out_valid[0]}, 32'd0);
        idle_all();

        // Random traffic against a per-channel scoreboard
        for (int n = 0; n < 3000; n++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_dest  = 2'($urandom_range(0, 3));
            in_data  = $urandom;
            for (int i = 0; i < 4; i++)
                out_ready[i] = 1'($urandom_range(0, 1));
            settle();
            exp_rdy = (q[in_dest].size() < 2);
            chk("rnd_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            for (int i = 0; i < 4; i++) begin
                chk("rnd_valid", {31'd0, out_valid[i]},
                    {31'd0, q[i].size() != 0});
                if (q[i].size() != 0)
                    chk("rnd_data", out_data[i], q[i][0]);
                do_pop[i] = out_ready[i] && (q[i].size() != 0);
            end
            for (int i = 0; i < 4; i++) out_ready[i] = !out_ready[i];
            settle();
            chk("rnd_no_comb", {31'd0, in_ready}, {31'd0, exp_rdy});
            for (int i = 0; i < 4; i++) out_ready[i] = !out_ready[i];
            do_push = in_valid && exp_rdy;
            p_dest  = in_dest;
            p_data  = in_data;
            tick();
            for (int i = 0; i < 4; i++)
                if (do_pop[i]) void'(q[i].pop_front());
            if (do_push) q[p_dest].push_back(p_data);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) out_ready[i] = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) q[i].delete();
        idle_all();

        // Out-of-range destination on LENGTH=3
        for (int i = 0; i < 3; i++) begin
            in_dest3 = 2'(i);
            settle();
            chk("l3_ready_in_range", {31'd0, in_ready3}, 32'd1);
        end
        in_dest3  = 2'd3;
        in_valid3 = 1'b1;
        for (int n = 0; n < 5; n++) begin
            in_data3 = 32'hD0 + 32'(n);
            settle();
            chk("l3_drop_ready", {31'd0, in_ready3}, 32'd1);
            tick();
            for (int i = 0; i < 3; i++)
                chk("l3_no_valid", {31'd0, out_valid3[i]}, 32'd0);
        end
`ifdef STREAM_DEMUX_DROP_COUNT_EN
        in_valid3 = 1'b0;
        settle();
        chk("drop_count_5", {16'd0, drop_count3}, 32'd5);
        chk("drop_count_l4", {16'd0, drop_count}, 32'd0);
        in_valid3 = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        chk("drop_count_sat", {16'd0, drop_count3}, 32'h0000FFFF);
`endif
        in_valid3 = 1'b0;

        // Reset while channels hold 2, 1, 0 beats
        in_valid = 1'b1;
        in_dest  = 2'd0;
        in_data  = 32'hC0;
        tick();
        in_data = 32'hC1;
        tick();
        in_dest = 2'd1;
        in_data = 32'hC2;
        tick();
        chk("pre_rst_v0", {31'd0, out_valid[0]}, 32'd1);
        chk("pre_rst_v1", {31'd0, out_valid[1]}, 32'd1);
        reset   = 1'b0;
        in_dest = 2'd2;
        in_data = 32'hC3;
        settle();
        chk("rst2_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        reset    = 1'b1;
        in_valid = 1'b0;
        settle();
        for (int i = 0; i < 4; i++)
            chk("post_rst_valid", {31'd0, out_valid[i]}, 32'd0);
`ifdef STREAM_DEMUX_DROP_COUNT_EN
        chk("post_rst_drop", {16'd0, drop_count3}, 32'd0);
`endif
        in_valid = 1'b1;
        in_dest  = 2'd0;
        in_data  = 32'hE0;
        tick();
        in_valid     = 1'b0;
        out_ready[0] = 1'b1;
        settle();
        chk("e0_valid", {31'd0, out_valid[0]}, 32'd1);
        chk("e0_data", out_data[0], 32'hE0);
        tick();
        chk("e0_alone", {31'd0, out_valid[0]}, 32'd0);
        chk("e0_ch2_empty", {31'd0, out_valid[2]}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
